// File: rtl/led_display_arbiter.sv
// Round-robin owner arbitration with minimum dwell for a shared 8-digit LED display, plus scan-tick divider.
// Optional macro LED_ARB_PRIO_EN makes requester 0 urgent (always wins, pre-empts other owners).
module led_display_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DWELL      = 256
) (
  input  logic                          clk_src,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [DATA_WIDTH-1:0]         led_data,
  output logic                          scan_tick,
  output logic                          busy,
  output logic [1:0]                    dbg_state_o
);

  localparam int IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DW_W  = $clog2(DWELL + 1);
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DW_W-1:0]    DWELL_MAX = DW_W'(DWELL);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);
  localparam logic [IW-1:0]      LAST_RST  = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    HANDOFF = 2'd2
  } state_e;

  state_e                  state_q;
  logic [IW-1:0]           last_q;
  logic [DIV_W-1:0]        div_q;
  logic [DW_W-1:0]         dwell_q;
  logic [NUM_REQ-1:0]      grant_q;
  logic [DATA_WIDTH-1:0]   led_q;
  logic                    tick_q;

  logic [DATA_WIDTH-1:0]   slice_w [NUM_REQ];
  logic [IW-1:0]           arb_idx_d;
  logic [IW-1:0]           cand;
  logic                    arb_hit;
  logic                    owner_req;
  logic                    other_req;
  logic                    dwell_done;
  logic                    preempt;
  logic                    leave_own;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign slice_w[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search starts just after the last owner, so the previous owner ranks last.
  always_comb begin
    arb_idx_d = last_q;
    arb_hit   = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((int'(last_q) + i) % NUM_REQ);
      if (!arb_hit && req[cand]) begin
        arb_hit   = 1'b1;
        arb_idx_d = cand;
      end
    end
`ifdef LED_ARB_PRIO_EN
    if (req[0]) begin
      arb_hit   = 1'b1;
      arb_idx_d = '0;
    end
`endif
  end

  // grant_q is the owner's one-hot while in OWN, so it doubles as the owner mask.
  assign owner_req  = |(req & grant_q);
  assign other_req  = |(req & ~grant_q);
  assign dwell_done = (dwell_q == DWELL_MAX);
`ifdef LED_ARB_PRIO_EN
  assign preempt    = req[0] & ~grant_q[0];
`else
  assign preempt    = 1'b0;
`endif
  assign leave_own  = !owner_req || (dwell_done && other_req) || preempt;

  always_ff @(posedge clk_src) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      led_q   <= '0;
      tick_q  <= 1'b0;
      div_q   <= '0;
      dwell_q <= '0;
      last_q  <= LAST_RST;
    end else begin
      div_q  <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      tick_q <= (div_q == DIV_LAST);
      case (state_q)
        IDLE, HANDOFF: begin
          if (arb_hit) begin
            state_q <= OWN;
            grant_q <= ONE_HOT0 << arb_idx_d;
            last_q  <= arb_idx_d;
            dwell_q <= '0;
            led_q   <= slice_w[arb_idx_d];
          end else begin
            state_q <= IDLE;
          end
        end
        OWN: begin
          if (tick_q && !dwell_done) dwell_q <= dwell_q + 1'b1;
          if (leave_own) begin
            state_q <= HANDOFF;
            grant_q <= '0;
          end else begin
            led_q <= slice_w[last_q];
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign grant       = grant_q;
  assign led_data    = led_q;
  assign scan_tick   = tick_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule
